// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch-PC sequencer and immediate-unit controller for the pipelined RV32 core.
// It decodes the decode-stage opcode into the immediate-generator select. It
// redirects fetch on JAL, JALR and taken branches. After each redirect it holds
// the IF/ID flush for FLUSH_CYCLES cycles.
//
// Optional feature: define PC_SEQ_HALT_EN to add the HALT state. In that build,
// EBREAK in decode halts fetch until a `resume` pulse arrives. Without the macro,
// EBREAK is an ordinary pc+4 instruction, `halted` is tied low and `resume` is
// not used.
//
// Parameters:
//   RESET_PC      fetch PC loaded on reset
//   FLUSH_CYCLES  cycles `flush` stays high after a redirect (1..7)
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   id_ins/id_pc  decode-stage instruction and its PC
//   id_valid      decode slot holds a real instruction
//   stall         hazard hold; freezes the PC while in RUN
//   br_taken      branch condition for id_ins
//   imm_target    PC-relative target from the immediate generator
//   jalr_target   rs1+imm for JALR
//   resume        leave HALT (single-cycle pulse)
//   imm_sel       immediate select (combinational)
//   pc            registered fetch PC
//   flush         registered IF/ID kill
//   redirect      registered one-cycle redirect pulse
//   halted        registered HALT indicator
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_ins,
    input  logic [31:0] id_pc,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] imm_target,
    input  logic [31:0] jalr_target,
    input  logic        resume,
    output logic [2:0]  imm_sel,
    output logic [31:0] pc,
    output logic        flush,
    output logic        redirect,
    output logic        halted
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

`ifdef PC_SEQ_HALT_EN
    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_RUN, S_FLUSH} state_t;
`endif

    state_t      state;
    logic [2:0]  fcnt;
    logic [6:0]  opcode;
    logic        take_redirect;
    logic [31:0] target;

    assign opcode = id_ins[6:0];

    // Immediate-format select; unknown opcodes get the spare code 101.
    always_comb begin
        imm_sel = 3'b101;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_sel = 3'b000;
            OP_STORE:                 imm_sel = 3'b001;
            OP_BRANCH:                imm_sel = 3'b010;
            OP_LUI, OP_AUIPC:         imm_sel = 3'b011;
            OP_JAL:                   imm_sel = 3'b100;
            default:                  imm_sel = 3'b101;
        endcase
    end

    // Redirect decision and target. JALR clears bit 0. B/J targets are used as given.
    always_comb begin
        take_redirect = id_valid && ((opcode == OP_JAL) || (opcode == OP_JALR) ||
                                     ((opcode == OP_BRANCH) && br_taken));
        target = (opcode == OP_JALR) ? {jalr_target[31:1], 1'b0} : imm_target;
    end

`ifdef PC_SEQ_HALT_EN
    logic is_ebreak;
    assign is_ebreak = id_valid && (id_ins == 32'h0010_0073);

    logic unused_bits;
    assign unused_bits = &{1'b0, jalr_target[0]};
`else
    assign halted = 1'b0;

    logic unused_bits;
    assign unused_bits = &{1'b0, jalr_target[0], resume, id_pc, id_ins[31:7]};
`endif

    // Sequencer. redirect defaults low, so it pulses for exactly one cycle.
    // fcnt loads FLUSH_CYCLES-1 so that flush stays high for FLUSH_CYCLES edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            pc       <= RESET_PC;
            flush    <= 1'b0;
            redirect <= 1'b0;
            fcnt     <= 3'd0;
`ifdef PC_SEQ_HALT_EN
            halted   <= 1'b0;
`endif
        end else begin
            redirect <= 1'b0;
            case (state)
                S_RUN: begin
                    if (stall) begin
                        // Hold. id_ins is held too, so a pending redirect fires later.
                    end else if (take_redirect) begin
                        pc       <= target;
                        redirect <= 1'b1;
                        flush    <= 1'b1;
                        fcnt     <= FLUSH_LOAD;
                        state    <= S_FLUSH;
                    end
`ifdef PC_SEQ_HALT_EN
                    else if (is_ebreak) begin
                        pc     <= id_pc + 32'd4;
                        halted <= 1'b1;
                        flush  <= 1'b1;
                        state  <= S_HALT;
                    end
`endif
                    else begin
                        pc <= pc + 32'd4;
                    end
                end
                S_FLUSH: begin
                    pc <= pc + 32'd4;
                    if (fcnt != 3'd0) begin
                        fcnt <= fcnt - 3'd1;
                    end else begin
                        flush <= 1'b0;
                        state <= S_RUN;
                    end
                end
`ifdef PC_SEQ_HALT_EN
                S_HALT: begin
                    if (resume) begin
                        halted <= 1'b0;
                        flush  <= 1'b0;
                        state  <= S_RUN;
                    end
                end
`endif
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed testbench for pc_sequencer with RESET_PC=32'h100 and FLUSH_CYCLES=2.
// A table of vectors covers the main sequencing. Hand-written sequences cover
// asynchronous reset in the middle of a flush and EBREAK/HALT handling. The
// HALT sequence follows the PC_SEQ_HALT_EN build setting.
module tb_pc_sequencer;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JAL    = 32'h0080_006F;
    localparam logic [31:0] BEQ    = 32'h0000_0063;
    localparam logic [31:0] JALR   = 32'h0000_8067;
    localparam logic [31:0] SW     = 32'h0000_2023;
    localparam logic [31:0] LUI    = 32'h0000_00B7;
    localparam logic [31:0] AUIPC  = 32'h0000_0097;
    localparam logic [31:0] ADD    = 32'h0000_0033;
    localparam logic [31:0] LW     = 32'h0000_0003;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        stall;
    logic        br_taken;
    logic [31:0] imm_target;
    logic [31:0] jalr_target;
    logic        resume;
    logic [2:0]  imm_sel;
    logic [31:0] pc;
    logic        flush;
    logic        redirect;
    logic        halted;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic        stall;
        logic        id_valid;
        logic [31:0] id_ins;
        logic [31:0] id_pc;
        logic        br_taken;
        logic [31:0] imm_target;
        logic [31:0] jalr_target;
        logic        resume;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_redirect;
        logic        exp_halted;
        logic [2:0]  exp_imm_sel;
    } vec_t;

    vec_t tbl[$];

    pc_sequencer #(
        .RESET_PC    (32'h0000_0100),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_ins     (id_ins),
        .id_pc      (id_pc),
        .id_valid   (id_valid),
        .stall      (stall),
        .br_taken   (br_taken),
        .imm_target (imm_target),
        .jalr_target(jalr_target),
        .resume     (resume),
        .imm_sel    (imm_sel),
        .pc         (pc),
        .flush      (flush),
        .redirect   (redirect),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds one vector. id_pc, resume and halted default to 0.
    function automatic vec_t vec(input logic s, input logic v, input logic [31:0] ins,
                                 input logic bt, input logic [31:0] imm, input logic [31:0] jt,
                                 input logic [31:0] epc, input logic ef, input logic er,
                                 input logic [2:0] esel);
        vec_t r;
        r.stall = s; r.id_valid = v; r.id_ins = ins; r.id_pc = 32'h0;
        r.br_taken = bt; r.imm_target = imm; r.jalr_target = jt; r.resume = 1'b0;
        r.exp_pc = epc; r.exp_flush = ef; r.exp_redirect = er;
        r.exp_halted = 1'b0; r.exp_imm_sel = esel;
        return r;
    endfunction

    // Drives a vector away from the clock edge, then waits until just after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        stall       = v.stall;
        id_valid    = v.id_valid;
        id_ins      = v.id_ins;
        id_pc       = v.id_pc;
        br_taken    = v.br_taken;
        imm_target  = v.imm_target;
        jalr_target = v.jalr_target;
        resume      = v.resume;
        @(posedge clk);
        #1;
    endtask

    // Compares every output with the expected value.
    task automatic checkOutput(input string name, input logic [31:0] epc, input logic ef,
                               input logic er, input logic eh, input logic [2:0] esel);
        assert_count += 5;
        if (pc !== epc) begin
            fail_count++;
            $display("[TB] FAIL %s pc: got %h expected %h", name, pc, epc);
        end
        if (flush !== ef) begin
            fail_count++;
            $display("[TB] FAIL %s flush: got %b expected %b", name, flush, ef);
        end
        if (redirect !== er) begin
            fail_count++;
            $display("[TB] FAIL %s redirect: got %b expected %b", name, redirect, er);
        end
        if (halted !== eh) begin
            fail_count++;
            $display("[TB] FAIL %s halted: got %b expected %b", name, halted, eh);
        end
        if (imm_sel !== esel) begin
            fail_count++;
            $display("[TB] FAIL %s imm_sel: got %b expected %b", name, imm_sel, esel);
        end
    endtask

    initial begin
        vec_t v;

        rst_n = 1'b0; stall = 1'b0; id_valid = 1'b0; id_ins = NOP; id_pc = 32'h0;
        br_taken = 1'b0; imm_target = 32'h0; jalr_target = 32'h0; resume = 1'b0;

        // Free-running fetch, then JAL with two flush cycles that ignore stall and valid inputs.
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'h104,0,0,3'b000));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'h108,0,0,3'b000));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'h10C,0,0,3'b000));
        tbl.push_back(vec(0,1,JAL,0,32'h200,32'h0,             32'h200,1,1,3'b100));
        tbl.push_back(vec(0,1,JAL,0,32'h300,32'h0,             32'h204,1,0,3'b100));
        tbl.push_back(vec(1,1,JAL,0,32'h300,32'h0,             32'h208,0,0,3'b100));
        // Taken branch held by stall for three cycles, then redirected.
        tbl.push_back(vec(1,1,BEQ,1,32'h40,32'h0,              32'h208,0,0,3'b010));
        tbl.push_back(vec(1,1,BEQ,1,32'h40,32'h0,              32'h208,0,0,3'b010));
        tbl.push_back(vec(1,1,BEQ,1,32'h40,32'h0,              32'h208,0,0,3'b010));
        tbl.push_back(vec(0,1,BEQ,1,32'h40,32'h0,              32'h040,1,1,3'b010));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'h044,1,0,3'b000));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'h048,0,0,3'b000));
        // Not-taken branch, then JALR with bit 0 cleared.
        tbl.push_back(vec(0,1,BEQ,0,32'h80,32'h0,              32'h04C,0,0,3'b010));
        tbl.push_back(vec(0,1,JALR,0,32'h0,32'h1235,           32'h1234,1,1,3'b000));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'h1238,1,0,3'b000));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'h123C,0,0,3'b000));
        // Remaining immediate formats.
        tbl.push_back(vec(0,1,SW,0,32'h0,32'h0,                32'h1240,0,0,3'b001));
        tbl.push_back(vec(0,1,LUI,0,32'h0,32'h0,               32'h1244,0,0,3'b011));
        tbl.push_back(vec(0,1,AUIPC,0,32'h0,32'h0,             32'h1248,0,0,3'b011));
        tbl.push_back(vec(0,1,ADD,0,32'h0,32'h0,               32'h124C,0,0,3'b101));
        tbl.push_back(vec(0,1,LW,0,32'h0,32'h0,                32'h1250,0,0,3'b000));
        // A JAL in a bubble slot does not redirect, and stall holds the PC.
        tbl.push_back(vec(0,0,JAL,0,32'h500,32'h0,             32'h1254,0,0,3'b100));
        tbl.push_back(vec(1,1,JAL,0,32'h500,32'h0,             32'h1254,0,0,3'b100));
        // Wrap from FFFF_FFFC to 0.
        tbl.push_back(vec(0,1,JAL,0,32'hFFFF_FFF4,32'h0,       32'hFFFF_FFF4,1,1,3'b100));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'hFFFF_FFF8,1,0,3'b000));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'hFFFF_FFFC,0,0,3'b000));
        tbl.push_back(vec(0,1,NOP,0,32'h0,32'h0,               32'h0000_0000,0,0,3'b000));
        // A misaligned target is loaded as given.
        tbl.push_back(vec(0,1,JAL,0,32'h102,32'h0,             32'h102,1,1,3'b100));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'h106,1,0,3'b000));
        tbl.push_back(vec(0,0,NOP,0,32'h0,32'h0,               32'h10A,0,0,3'b000));

        #12;
        checkOutput("reset", 32'h100, 1'b0, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_flush,
                        tbl[i].exp_redirect, tbl[i].exp_halted, tbl[i].exp_imm_sel);
        end

        // Asynchronous reset in the middle of a flush.
        applyStimulus(vec(0,1,JAL,0,32'h600,32'h0, 32'h600,1,1,3'b100));
        checkOutput("jal_before_reset", 32'h600, 1'b1, 1'b1, 1'b0, 3'b100);
        id_valid = 1'b0; id_ins = NOP;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_mid_flush", 32'h100, 1'b0, 1'b0, 1'b0, 3'b000);
        #1 rst_n = 1'b1;
        applyStimulus(vec(0,0,NOP,0,32'h0,32'h0, 32'h104,0,0,3'b000));
        checkOutput("after_reset_flush", 32'h104, 1'b0, 1'b0, 1'b0, 3'b000);

`ifdef PC_SEQ_HALT_EN
        // EBREAK halts fetch at id_pc+4, and stall and decode inputs are ignored while halted.
        v = vec(0,1,EBREAK,0,32'h0,32'h0, 32'h0,0,0,3'b000);
        v.id_pc = 32'h80;
        applyStimulus(v);
        checkOutput("ebreak_enter", 32'h84, 1'b1, 1'b0, 1'b1, 3'b101);
        for (int i = 0; i < 10; i++) begin
            v = vec(i[0],1,JAL,0,32'h900,32'h0, 32'h0,0,0,3'b000);
            applyStimulus(v);
            checkOutput($sformatf("halt_hold%0d", i), 32'h84, 1'b1, 1'b0, 1'b1, 3'b100);
        end
        // resume has priority over a simultaneous stall.
        v = vec(1,0,NOP,0,32'h0,32'h0, 32'h0,0,0,3'b000);
        v.resume = 1'b1;
        applyStimulus(v);
        checkOutput("resume", 32'h84, 1'b0, 1'b0, 1'b0, 3'b000);
        applyStimulus(vec(0,0,NOP,0,32'h0,32'h0, 32'h0,0,0,3'b000));
        checkOutput("after_resume", 32'h88, 1'b0, 1'b0, 1'b0, 3'b000);
        // resume outside HALT has no effect.
        v = vec(0,0,NOP,0,32'h0,32'h0, 32'h0,0,0,3'b000);
        v.resume = 1'b1;
        applyStimulus(v);
        checkOutput("resume_in_run", 32'h8C, 1'b0, 1'b0, 1'b0, 3'b000);
        // Reset abandons the halt immediately.
        v = vec(0,1,EBREAK,0,32'h0,32'h0, 32'h0,0,0,3'b000);
        v.id_pc = 32'h200;
        applyStimulus(v);
        checkOutput("ebreak_again", 32'h204, 1'b1, 1'b0, 1'b1, 3'b101);
        id_valid = 1'b0; id_ins = NOP;
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_mid_halt", 32'h100, 1'b0, 1'b0, 1'b0, 3'b000);
        #1 rst_n = 1'b1;
        applyStimulus(vec(0,0,NOP,0,32'h0,32'h0, 32'h0,0,0,3'b000));
        checkOutput("after_reset_halt", 32'h104, 1'b0, 1'b0, 1'b0, 3'b000);
`else
        // Without HALT support, EBREAK is an ordinary pc+4 instruction and resume does nothing.
        v = vec(0,1,EBREAK,0,32'h0,32'h0, 32'h0,0,0,3'b000);
        v.id_pc = 32'h80;
        applyStimulus(v);
        checkOutput("ebreak_plain", 32'h108, 1'b0, 1'b0, 1'b0, 3'b101);
        v = vec(0,0,NOP,0,32'h0,32'h0, 32'h0,0,0,3'b000);
        v.resume = 1'b1;
        applyStimulus(v);
        checkOutput("resume_unused", 32'h10C, 1'b0, 1'b0, 1'b0, 3'b000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
